// File: rtl/cache_axi_bridge_pkg.sv
// Shared request encodings, FSM state types and AXI burst helpers for the
// cache-to-AXI bridge.
package cache_axi_bridge_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

  // Returns {len[7:0], size[2:0]}: a line is a full word burst, anything
  // else is a single beat sized by the low type bits.
  function automatic logic [10:0] burst_fields(input logic [2:0] t, input int line_words);
    if (t == TYPE_LINE) return {8'(line_words - 1), 3'd2};
    return {8'd0, 1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/axi_wr_engine.sv
// Write side of the bridge: latches one cache write, drives AW and W
// concurrently, then waits for the B response.
module axi_wr_engine
  import cache_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [2:0]               type_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [3:0]               wstrb_i,
  input  logic [LINE_WORDS*32-1:0] data_i,
  output w_state_e                 state_o,
  output logic [ADDR_W-5:0]        line_addr_o,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  w_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [2:0]                type_q, type_d;
  logic [3:0]                strb_q, strb_d;
  logic [LINE_WORDS*32-1:0]  data_q, data_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;

  logic                      is_line;
  logic [CNT_W-1:0]          word_idx;
  logic [31:0]               words [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
    addr_q <= addr_d;
    type_q <= type_d;
    strb_q <= strb_d;
    data_q <= data_d;
  end

  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) words[k] = data_q[32*k +: 32];
  end

  // Single writes pick the addressed word of the line; a line walks the beat counter.
  assign is_line     = (type_q == TYPE_LINE);
  assign word_idx    = is_line ? cnt_q : addr_q[2 +: CNT_W];
  assign wdata       = words[word_idx];
  assign wstrb       = is_line ? 4'hf : strb_q;
  assign wlast       = is_line ? (cnt_q == CNT_W'(LINE_WORDS - 1)) : 1'b1;
  assign awaddr      = addr_q;
  assign {awlen, awsize} = burst_fields(type_q, LINE_WORDS);
  assign state_o     = state_q;
  assign line_addr_o = addr_q[ADDR_W-1:4];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    strb_d    = strb_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (req) begin
          addr_d    = addr_i;
          type_d    = type_i;
          strb_d    = wstrb_i;
          data_d    = data_i;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = W_SEND;
        end
      end
      W_SEND: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready) begin
          cnt_d = cnt_q + 1'b1;
          if (wlast) w_done_d = 1'b1;
        end
        // AW and the last W beat may complete in either order or together.
        if (aw_done_d && w_done_d) state_d = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss-side to AXI4 master bridge: read FSM here, write engine in a
// sub-module; reads to a line with a pending write are held off.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [LINE_WORDS*32-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready
);

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        rd_type_q, rd_type_d;

  w_state_e          wr_state;
  logic [ADDR_W-5:0] wr_line;
  logic              wr_idle;
  logic              rd_hazard;

  axi_wr_engine #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) u_wr (
    .clk         (clk),
    .reset       (reset),
    .req         (wr_req),
    .type_i      (wr_type),
    .addr_i      (wr_addr),
    .wstrb_i     (wr_wstrb),
    .data_i      (wr_data),
    .state_o     (wr_state),
    .line_addr_o (wr_line),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .bvalid      (bvalid),
    .bready      (bready)
  );

  assign wr_idle = (wr_state == W_IDLE);
  assign wr_rdy  = !reset && wr_idle;

  // Block a read whose line is being written now or is still in flight.
  assign rd_hazard = (!wr_idle && (rd_addr[ADDR_W-1:4] == wr_line)) ||
                     (wr_req && wr_rdy && (rd_addr[ADDR_W-1:4] == wr_addr[ADDR_W-1:4]));
  assign rd_rdy    = !reset && (rd_state_q == R_IDLE) && !rd_hazard;

  assign araddr          = rd_addr_q;
  assign {arlen, arsize} = burst_fields(rd_type_q, LINE_WORDS);
  assign ret_data        = rdata;

  always_ff @(posedge clk) begin
    if (reset) rd_state_q <= R_IDLE;
    else       rd_state_q <= rd_state_d;
    rd_addr_q <= rd_addr_d;
    rd_type_q <= rd_type_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_type_d  = rd_type_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ret_valid  = 1'b0;
    ret_last   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          rd_addr_d  = rd_addr;
          rd_type_d  = rd_type;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rvalid && rlast;
        if (rvalid && rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Converts the cache's miss-side request interface into AXI4 master transactions. Cache side: rd_req/rd_type/rd_addr plus wr_req/wr_type/wr_addr/wr_wstrb/wr_data.
- Sits directly downstream of the data cache; refills and write-backs go through it to the system bus.
- Independent read and write engines, one outstanding transaction each.
- Reads are held off while a pending write targets the same cache line.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line. Line burst is LINE_WORDS beats; line data width is LINE_WORDS*32.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read request, accepted when rd_req && rd_rdy.
- rd_type  in  3  000 byte, 001 half, 010 word, 100 cache line.
- rd_addr  in  ADDR_W  read byte address.
- rd_rdy  out  1  bridge can accept a read this cycle.
- ret_valid  out  1  one returned read word this cycle.
- ret_last  out  1  final returned word of the request.
- ret_data  out  32  returned word.
- wr_req  in  1  write request, accepted when wr_req && wr_rdy.
- wr_type  in  3  same encoding as rd_type.
- wr_addr  in  ADDR_W  write byte address.
- wr_wstrb  in  4  byte strobes; used only for non-line types.
- wr_data  in  LINE_WORDS*32  line data; word k occupies bits [32k+31:32k].
- wr_rdy  out  1  bridge can accept a write this cycle.
- arvalid / arready  out / in  1 / 1  AR handshake.
- araddr / arlen / arsize  out  ADDR_W / 8 / 3  read address, beats-1, log2(bytes per beat).
- rvalid / rready / rdata / rlast  in / out / in / in  1 / 1 / 32 / 1  R channel.
- awvalid / awready  out / in  1 / 1  AW handshake.
- awaddr / awlen / awsize  out  ADDR_W / 8 / 3  write address fields.
- wvalid / wready / wdata / wstrb / wlast  out / in / out / out / out  1 / 1 / 32 / 4 / 1  W channel.
- bvalid / bready  in / out  1 / 1  B channel.

Behaviour:
- Reset, and the cycle after reset deasserts:
  - arvalid, awvalid, wvalid, rready, bready, ret_valid and ret_last are 0.
  - rd_rdy and wr_rdy are 0 while reset is high and 1 once idle.
- Burst fields:
  - Line type (100): len = LINE_WORDS-1, size = 2.
  - Other types: len = 0, size = type[1:0].
  - Addresses are passed through unchanged. Burst type is INCR. rresp, bresp and IDs are ignored.
- Read FSM, states R_IDLE -> R_AR -> R_DATA -> R_IDLE:
  - Acceptance is in R_IDLE only; address and type are latched.
  - arvalid rises the cycle after acceptance and holds with stable fields until arready.
  - In R_DATA, rready = 1. ret_valid = rvalid, ret_data = rdata, ret_last = rvalid && rlast.
  - The rlast beat returns the FSM to R_IDLE; rd_rdy = 1 the next cycle.
- Write FSM, states W_IDLE -> W_SEND -> W_RESP -> W_IDLE:
  - wr_rdy = W_IDLE. On acceptance, address, type, strobes and data are latched.
  - In W_SEND, awvalid and wvalid are both raised the cycle after acceptance.
  - awvalid drops after the aw handshake.
  - A beat counter advances on each w handshake.
  - Line write: wdata = word[cnt], wstrb = 4'hf, wlast when cnt == LINE_WORDS-1.
  - Single write: wdata = word[wr_addr[3:2]], wstrb = latched wr_wstrb, wlast = 1.
  - Move to W_RESP once both the aw handshake and the last w handshake have completed, in either order or in the same cycle.
  - In W_RESP, bready = 1; the bvalid handshake returns the FSM to W_IDLE.
- Read-after-write hazard:
  - rd_rdy = 0 when the write FSM is not idle and rd_addr[ADDR_W-1:4] equals the latched write line address.
  - rd_rdy = 0 when a write to the same line is being accepted in the same cycle.
  - A read and a write to different lines in the same cycle are both accepted.
- Reset mid-transaction: both FSMs go idle and in-flight bus transactions are abandoned. The bus slave is reset by the same reset.

Decomposition:
- Shared package:
  - RD/WR type encodings: TYPE_BYTE = 000, TYPE_HALF = 001, TYPE_WORD = 010, TYPE_LINE = 100.
  - AXI_BURST_INCR.
  - A function mapping type to {len, size}.
- One sub-module: axi_wr_engine, which holds the W_* FSM, the beat counter and the data mux. The read FSM stays in the top module.

Test Plan:
1. Line read: rd_req, type 100, addr 0x1c000040 -> next cycle arvalid = 1 with araddr 0x1c000040, arlen 3, arsize 2. Slave returns A0..A3 with rlast on A3 -> four ret_valid cycles carrying A0..A3, ret_last only on A3; rd_rdy = 1 the cycle after A3.
2. Word read: type 010, addr 0xbfaf8004 -> arlen 0, arsize 2; one beat 0xdeadbeef gives ret_valid = ret_last = 1 with ret_data 0xdeadbeef.
3. Line write: addr 0x00001230, data words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (word 0 first). awready delayed 3 cycles -> awaddr 0x1230, awlen 3; wdata sent in that order with wstrb f and wlast on the 4th beat; wr_rdy = 0 until the cycle after the bvalid handshake.
4. Word write: type 010, addr 0xbfaf8008, wstrb 0011 -> awlen 0, wdata = wr_data[95:64], wstrb 0011, wlast = 1.
5. Hazard: write to line 0x1230 with bvalid delayed 10 cycles. A read to 0x1234 sees rd_rdy = 0 until the cycle after the b handshake. A read to 0x2000 issued meanwhile is accepted immediately.
6. Robustness: arready held low 5 cycles -> arvalid and araddr stay stable. Reset asserted mid read burst -> next cycle all valids and readies are 0, then rd_rdy = wr_rdy = 1 after reset deasserts.
